// File: rtl/qpolicy_reader.sv
// Greedy policy walker: reads four Q entries per state, picks the best action,
// follows the next-state table and hands each step to a valid/ready consumer.
module qpolicy_reader #(
  parameter int STATE_WIDTH = 6,
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 8,
  parameter int MAX_STEPS   = 64
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_start,
  input  logic [STATE_WIDTH-1:0]  i_start_state,
  input  logic [STATE_WIDTH-1:0]  i_end_state,
  output logic                    o_busy,
  output logic                    o_q_rd,
  output logic [ADDR_WIDTH-1:0]   o_q_addr,
  input  logic [DATA_WIDTH-1:0]   i_q_data,
  output logic                    o_ns_rd,
  output logic [ADDR_WIDTH-1:0]   o_ns_addr,
  input  logic [ADDR_WIDTH-1:0]   i_ns_data,
  output logic                    o_step_valid,
  input  logic                    i_step_ready,
  output logic [STATE_WIDTH-1:0]  o_step_state,
  output logic [1:0]              o_step_action,
  output logic [DATA_WIDTH-1:0]   o_step_q,
  output logic                    o_done,
  output logic                    o_done_limit,
  output logic [STATE_WIDTH:0]    o_step_count
);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_READ = 3'd1;
  localparam logic [2:0] ST_WAIT = 3'd2;
  localparam logic [2:0] ST_NS   = 3'd3;
  localparam logic [2:0] ST_EMIT = 3'd4;
  localparam logic [2:0] ST_DONE = 3'd5;

  localparam logic [STATE_WIDTH:0] MAX_CNT = (STATE_WIDTH+1)'(MAX_STEPS);

  logic [2:0]             state_q, state_d;
  logic [STATE_WIDTH-1:0] s_q, s_d;
  logic [STATE_WIDTH-1:0] end_q, end_d;
  logic [STATE_WIDTH-1:0] next_s_q, next_s_d;
  logic [1:0]             act_q, act_d;
  logic [1:0]             cmp_act_q, cmp_act_d;
  logic                   cmp_en_q, cmp_en_d;
  logic [1:0]             best_act_q, best_act_d;
  logic [DATA_WIDTH-1:0]  best_q, best_d;
  logic                   ns_pend_q, ns_pend_d;
  logic [STATE_WIDTH:0]   count_q, count_d;
  logic                   limit_q, limit_d;
  logic [STATE_WIDTH-1:0] ns_eff;

  // Next-state data lands in the first EMIT cycle; later cycles use the copy.
  assign ns_eff = ns_pend_q ? i_ns_data[STATE_WIDTH-1:0] : next_s_q;

  always_comb begin
    state_d    = state_q;
    s_d        = s_q;
    end_d      = end_q;
    next_s_d   = next_s_q;
    act_d      = act_q;
    best_act_d = best_act_q;
    best_d     = best_q;
    ns_pend_d  = 1'b0;
    count_d    = count_q;
    limit_d    = limit_q;
    cmp_en_d   = (state_q == ST_READ);
    cmp_act_d  = act_q;

    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          s_d     = i_start_state;
          end_d   = i_end_state;
          count_d = '0;
          limit_d = 1'b0;
          act_d   = 2'd0;
          state_d = (i_start_state == i_end_state) ? ST_DONE : ST_READ;
        end
      end
      ST_READ: begin
        act_d = act_q + 2'd1;
        if (act_q == 2'd3) state_d = ST_WAIT;
      end
      ST_WAIT: state_d = ST_NS;
      ST_NS: begin
        ns_pend_d = 1'b1;
        state_d   = ST_EMIT;
      end
      ST_EMIT: begin
        next_s_d = ns_eff;
        if (i_step_ready) begin
          count_d = count_q + (STATE_WIDTH+1)'(1);
          s_d     = ns_eff;
          act_d   = 2'd0;
          if (ns_eff == end_q) begin
            limit_d = 1'b0;
            state_d = ST_DONE;
          end else if (count_d == MAX_CNT) begin
            limit_d = 1'b1;
            state_d = ST_DONE;
          end else begin
            state_d = ST_READ;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Strictly-greater replacement keeps the lowest action on ties.
    if (cmp_en_q && ((cmp_act_q == 2'd0) || (i_q_data > best_q))) begin
      best_d     = i_q_data;
      best_act_d = cmp_act_q;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= ST_IDLE;
      s_q        <= '0;
      end_q      <= '0;
      next_s_q   <= '0;
      act_q      <= '0;
      cmp_act_q  <= '0;
      cmp_en_q   <= 1'b0;
      best_act_q <= '0;
      best_q     <= '0;
      ns_pend_q  <= 1'b0;
      count_q    <= '0;
      limit_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      s_q        <= s_d;
      end_q      <= end_d;
      next_s_q   <= next_s_d;
      act_q      <= act_d;
      cmp_act_q  <= cmp_act_d;
      cmp_en_q   <= cmp_en_d;
      best_act_q <= best_act_d;
      best_q     <= best_d;
      ns_pend_q  <= ns_pend_d;
      count_q    <= count_d;
      limit_q    <= limit_d;
    end
  end

  always_comb begin
    o_busy        = (state_q != ST_IDLE);
    o_q_rd        = (state_q == ST_READ);
    o_q_addr      = o_q_rd ? {s_q, act_q} : '0;
    o_ns_rd       = (state_q == ST_NS);
    o_ns_addr     = o_ns_rd ? {s_q, best_act_q} : '0;
    o_step_valid  = (state_q == ST_EMIT);
    o_step_state  = o_step_valid ? s_q : '0;
    o_step_action = o_step_valid ? best_act_q : 2'd0;
    o_step_q      = o_step_valid ? best_q : '0;
    o_done        = (state_q == ST_DONE);
    o_done_limit  = o_done & limit_q;
    o_step_count  = count_q;
  end

endmodule

// File: tb/tb_qpolicy_reader.sv
// Directed + randomized walks of qpolicy_reader against a table-walking
// reference model; single-cycle registered table memories feed the DUT.
module tb_qpolicy_reader;
  localparam int SW   = 6;
  localparam int AW   = 8;
  localparam int DW   = 8;
  localparam int MAXS = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_start;
  logic [SW-1:0] i_start_state, i_end_state;
  logic          o_busy, o_q_rd, o_ns_rd;
  logic [AW-1:0] o_q_addr, o_ns_addr;
  logic [DW-1:0] q_data;
  logic [AW-1:0] ns_data;
  logic          o_step_valid, i_step_ready;
  logic [SW-1:0] o_step_state;
  logic [1:0]    o_step_action;
  logic [DW-1:0] o_step_q;
  logic          o_done, o_done_limit;
  logic [SW:0]   o_step_count;

  qpolicy_reader #(
    .STATE_WIDTH(SW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_STEPS(MAXS)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(i_start),
    .i_start_state(i_start_state), .i_end_state(i_end_state),
    .o_busy(o_busy), .o_q_rd(o_q_rd), .o_q_addr(o_q_addr), .i_q_data(q_data),
    .o_ns_rd(o_ns_rd), .o_ns_addr(o_ns_addr), .i_ns_data(ns_data),
    .o_step_valid(o_step_valid), .i_step_ready(i_step_ready),
    .o_step_state(o_step_state), .o_step_action(o_step_action), .o_step_q(o_step_q),
    .o_done(o_done), .o_done_limit(o_done_limit), .o_step_count(o_step_count)
  );

  // clock / tables
  always #5 clk = ~clk;

  logic [DW-1:0] qtab [256];
  logic [AW-1:0] nstab[256];

  // Data is valid one cycle after the strobe; garbage otherwise.
  always @(posedge clk) begin
    q_data  <= o_q_rd  ? qtab[o_q_addr]   : DW'($urandom);
    ns_data <= o_ns_rd ? nstab[o_ns_addr] : AW'($urandom);
  end

  // scoreboard state
  int n_cmp = 0;
  int n_err = 0;
  int q_rd_total = 0;
  int ns_rd_total = 0;
  logic [15:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One cycle: advance to the falling edge and check strobe/address invariants.
  task automatic tick();
    @(negedge clk);
    if (o_q_rd)  q_rd_total++;
    if (o_ns_rd) ns_rd_total++;
    chk("strobe_exclusive", 32'(o_q_rd & o_ns_rd), 32'd0);
    chk("q_addr_idle",  o_q_rd  ? 32'd0 : 32'(o_q_addr),  32'd0);
    chk("ns_addr_idle", o_ns_rd ? 32'd0 : 32'(o_ns_addr), 32'd0);
  endtask

  // reference model
  function automatic logic [1:0] greedy(input logic [SW-1:0] s);
    logic [1:0] b;
    b = 2'd0;
    for (int a = 1; a < 4; a++)
      if (qtab[{s, 2'(a)}] > qtab[{s, b}]) b = 2'(a);
    return b;
  endfunction

  task automatic build_expected(input logic [SW-1:0] st, input logic [SW-1:0] en,
                                output int ecnt, output logic elim);
    logic [SW-1:0] s;
    logic [1:0]    a;
    exp_q.delete();
    s = st; ecnt = 0; elim = 1'b0;
    if (st != en) begin
      for (int i = 0; i < 1000; i++) begin
        a = greedy(s);
        exp_q.push_back({s, a, qtab[{s, a}]});
        ecnt++;
        s = nstab[{s, a}][SW-1:0];
        if (s == en) break;
        if (ecnt == MAXS) begin
          elim = 1'b1;
          break;
        end
      end
    end
  endtask

  // driver: one complete walk, every step checked against the model
  task automatic do_walk(input logic [SW-1:0] st, input logic [SW-1:0] en,
                         input int stall_min, input int stall_max);
    int ecnt, cyc, steps, stall, qb, nb;
    logic elim;
    logic [15:0] e;
    build_expected(st, en, ecnt, elim);
    qb = q_rd_total; nb = ns_rd_total;
    i_start = 1'b1; i_start_state = st; i_end_state = en;
    tick();
    i_start = 1'b0;
    i_start_state = SW'($urandom); i_end_state = SW'($urandom);
    steps = 0;
    while (exp_q.size() > 0) begin
      cyc = 0;
      while (!o_step_valid && !o_done && cyc < 100) begin
        tick();
        cyc++;
      end
      chk("step_latency", 32'(cyc), 32'd6);
      chk("step_valid", 32'(o_step_valid), 32'd1);
      if (!o_step_valid) break;
      e = exp_q.pop_front();
      chk("step_state",  32'(o_step_state),  32'(e[15:10]));
      chk("step_action", 32'(o_step_action), 32'(e[9:8]));
      chk("step_q",      32'(o_step_q),      32'(e[7:0]));
      chk("step_count_mid", 32'(o_step_count), 32'(steps));
      chk("q_reads_per_step",  32'(q_rd_total - qb),  32'd4);
      chk("ns_reads_per_step", 32'(ns_rd_total - nb), 32'd1);
      stall = $urandom_range(stall_max, stall_min);
      for (int k = 0; k < stall; k++) begin
        tick();
        chk("stall_valid",  32'(o_step_valid),  32'd1);
        chk("stall_state",  32'(o_step_state),  32'(e[15:10]));
        chk("stall_action", 32'(o_step_action), 32'(e[9:8]));
        chk("stall_q",      32'(o_step_q),      32'(e[7:0]));
        chk("stall_no_reads", 32'((q_rd_total - qb) + (ns_rd_total - nb)), 32'd5);
      end
      i_step_ready = 1'b1;
      qb = q_rd_total; nb = ns_rd_total;
      tick();
      i_step_ready = 1'b0;
      steps++;
    end
    chk("done_pulse", 32'(o_done), 32'd1);
    chk("done_limit", 32'(o_done_limit), 32'(elim));
    chk("done_count", 32'(o_step_count), 32'(ecnt));
    chk("done_no_valid", 32'(o_step_valid), 32'd0);
    if (ecnt == 0) chk("no_table_reads", 32'((q_rd_total - qb) + (ns_rd_total - nb)), 32'd0);
    tick();
    chk("done_one_cycle", 32'(o_done), 32'd0);
    chk("idle_not_busy", 32'(o_busy), 32'd0);
    chk("count_held", 32'(o_step_count), 32'(ecnt));
  endtask

  task automatic fill_random(input int qmax);
    for (int i = 0; i < 256; i++) begin
      qtab[i]  = DW'($urandom_range(qmax, 0));
      nstab[i] = AW'($urandom);
    end
  endtask

  task automatic make_cycle_23();
    for (int a = 0; a < 4; a++) begin
      nstab[{6'd2, 2'(a)}] = {2'($urandom), 6'd3};
      nstab[{6'd3, 2'(a)}] = {2'($urandom), 6'd2};
    end
  endtask

  initial begin
    logic [SW-1:0] st, en;
    int cyc;
    rst_n = 1'b0; i_start = 1'b0; i_step_ready = 1'b0;
    i_start_state = '0; i_end_state = '0;
    fill_random(255);
    repeat (3) tick();
    chk("reset_busy",  32'(o_busy), 32'd0);
    chk("reset_valid", 32'(o_step_valid), 32'd0);
    chk("reset_done",  32'(o_done), 32'd0);
    chk("reset_count", 32'(o_step_count), 32'd0);
    rst_n = 1'b1;
    tick();

    // single step: row 5 = {3,9,9,2}, tie between a1/a2 picks a1
    qtab[{6'd5, 2'd0}] = 8'd3; qtab[{6'd5, 2'd1}] = 8'd9;
    qtab[{6'd5, 2'd2}] = 8'd9; qtab[{6'd5, 2'd3}] = 8'd2;
    nstab[{6'd5, 2'd1}] = 8'd7;
    chk("model_row5_action", 32'(greedy(6'd5)), 32'd1);
    do_walk(6'd5, 6'd7, 0, 2);

    // start equals end
    do_walk(6'd12, 6'd12, 0, 0);

    // 2 -> 3 -> 2 loop, end unreachable: step limit
    fill_random(255);
    make_cycle_23();
    do_walk(6'd2, 6'd40, 0, 3);

    // consumer stalls ten cycles on every step
    do_walk(6'd2, 6'd40, 10, 10);

    // reset during the READ phase of the second step
    i_start = 1'b1; i_start_state = 6'd2; i_end_state = 6'd40;
    tick();
    i_start = 1'b0;
    cyc = 0;
    while (!o_step_valid && cyc < 100) begin tick(); cyc++; end
    chk("pre_reset_valid", 32'(o_step_valid), 32'd1);
    i_step_ready = 1'b1;
    tick();
    i_step_ready = 1'b0;
    tick();
    chk("pre_reset_reading", 32'(o_q_rd), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_reset_busy",  32'(o_busy), 32'd0);
    chk("mid_reset_q_rd",  32'(o_q_rd), 32'd0);
    chk("mid_reset_addr",  32'(o_q_addr), 32'd0);
    chk("mid_reset_valid", 32'(o_step_valid), 32'd0);
    chk("mid_reset_done",  32'(o_done), 32'd0);
    chk("mid_reset_count", 32'(o_step_count), 32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    chk("post_reset_idle", 32'(o_busy), 32'd0);
    do_walk(6'd2, 6'd40, 0, 2);

    // all Q values equal: action 0 every step
    for (int i = 0; i < 256; i++) begin
      qtab[i]  = 8'hFF;
      nstab[i] = AW'($urandom);
    end
    do_walk(6'($urandom), 6'($urandom), 0, 1);

    // randomized walks, small Q range to provoke ties
    for (int w = 0; w < 8; w++) begin
      fill_random((w % 2 == 0) ? 3 : 255);
      st = 6'($urandom);
      en = ($urandom_range(1, 0) == 1) ? nstab[{st, greedy(st)}][SW-1:0] : 6'($urandom);
      do_walk(st, en, 0, 4);
      repeat ($urandom_range(3, 0)) tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/qpolicy_reader.md
QPOLICY_READER -- requirements
Module: qpolicy_reader

Interface
REQ-001 Parameters SHALL be:
- STATE_WIDTH, default 6, state index width.
- ADDR_WIDTH, default 8, table address width; equals STATE_WIDTH+2.
- DATA_WIDTH, default 8, unsigned Q-value width.
- MAX_STEPS, default 64, walk step limit; ≥1.

REQ-002 Ports SHALL be (name, direction, width, meaning):
- i_clk  in  1  single clock; all logic on its rising edge.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_start  in  1  walk request; sampled in IDLE only.
- i_start_state  in  STATE_WIDTH  first state of the walk.
- i_end_state  in  STATE_WIDTH  terminal state.
- o_busy  out  1  high whenever not in IDLE.
- o_q_rd  out  1  Q-table read strobe.
- o_q_addr  out  ADDR_WIDTH  Q-table address {state,action}.
- i_q_data  in  DATA_WIDTH  Q-table data, valid one cycle after o_q_rd.
- o_ns_rd  out  1  next-state-table read strobe.
- o_ns_addr  out  ADDR_WIDTH  next-state address {state,action}.
- i_ns_data  in  ADDR_WIDTH  next-state data, valid one cycle after o_ns_rd; low STATE_WIDTH bits used.
- o_step_valid  out  1  greedy step available.
- i_step_ready  in  1  consumer accepts step.
- o_step_state  out  STATE_WIDTH  current state.
- o_step_action  out  2  greedy action.
- o_step_q  out  DATA_WIDTH  Q value of the greedy action.
- o_done  out  1  one-cycle walk-complete pulse.
- o_done_limit  out  1  1 = walk ended on MAX_STEPS; 0 = walk reached end state; valid with o_done.
- o_step_count  out  STATE_WIDTH+1  accepted steps of the current or last walk.

Function
REQ-003 The block SHALL be the read-side counterpart of the Q-learning update pipeline: it only reads the Q and next-state tables and never writes either.
REQ-004 FSM states SHALL be IDLE, READ, WAIT, NS, EMIT, DONE.
REQ-005 IDLE, i_start=1: the block SHALL latch the start state, latch the end state, and clear o_step_count.
- Start state equals end state: go to DONE.
- Otherwise: go to READ with action counter a=0.
REQ-006 READ SHALL last exactly 4 cycles: o_q_rd=1 and o_q_addr={s,a} for a=0,1,2,3 in order, then go to WAIT.
REQ-007 Each cycle after a READ cycle SHALL compare i_q_data against the running best.
- a=0 loads the best unconditionally.
- a>0 replaces the best only if strictly greater (unsigned), so ties select the lowest action.
REQ-008 WAIT SHALL consume the a=3 data, then go to NS.
REQ-009 NS SHALL assert o_ns_rd=1 with o_ns_addr={s,best_action} for one cycle, then go to EMIT.
REQ-010 On entry to EMIT the block SHALL capture i_ns_data[STATE_WIDTH-1:0] as the next state.
REQ-011 In EMIT, o_step_valid SHALL be 1 with o_step_state, o_step_action and o_step_q stable until the cycle with i_step_ready=1.
REQ-012 On accept (valid&ready) the block SHALL increment the count and set s to the next state, then:
- next state equals end state: go to DONE, limit=0.
- else new count equals MAX_STEPS: go to DONE, limit=1.
- else: go to READ.
REQ-013 DONE SHALL assert o_done=1 for exactly one cycle with o_done_limit valid, then go to IDLE; o_step_count SHALL hold its value until the next start.
REQ-014 The first o_step_valid SHALL rise 6 rising edges after the edge sampling i_start; each further step SHALL take at least 7 cycles.
REQ-015 i_start SHALL be ignored outside IDLE.
REQ-016 o_q_rd and o_ns_rd SHALL never be high in the same cycle.
REQ-017 Strobe outputs SHALL be 0 outside their states; address outputs SHALL be 0 when their strobe is 0.

Reset
REQ-018 i_rst_n=0 SHALL immediately force IDLE and zero all outputs and internal registers, including mid-walk; no pending step or o_done pulse SHALL survive reset.

Verification
REQ-019 Walk: Q row s=5 = {3,9,9,2} (a0..a3), next-state(5,1)=7, start=5, end=7 -> one step (state 5, action 1, q 9); then o_done=1, limit=0, count=1.
REQ-020 Start=end=12 -> o_done pulses 1 cycle after start; count=0, limit=0; no table reads issued.
REQ-021 Cycle 2→3→2 with end state 40 unreachable, MAX_STEPS=4 -> 4 steps emitted; o_done with limit=1, count=4.
REQ-022 i_step_ready held low 10 cycles in EMIT -> o_step_valid and payload stable all 10 cycles; no new reads issued.
REQ-023 i_rst_n pulsed low during READ of step 2 -> outputs 0 immediately; a fresh i_start afterwards walks correctly from the first step.
REQ-024 All Q values equal (0xFF) -> action 0 selected at every step.
